ddr3_app_arbiter: RTL

DDR3_APP_ARBITER -- requirements
Module: ddr3_app_arbiter

---
 rtl/ddr3_app_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ddr3_app_arbiter.sv
// Two-port round-robin front end for the MIG app interface; one command held at a time, 2+ cycles each.
// Read tags are queued in issue order so returned data is routed to its requester one cycle later.
module ddr3_app_arbiter #(
   parameter int ADDR_W   = 29,
   parameter int DATA_W   = 256,
   parameter int RD_DEPTH = 16
) (
   input  logic                       ui_clk,
   input  logic                       ui_clk_sync_rst,
   input  logic                       init_calib_complete,
   input  logic                       p0_req_valid,
   output logic                       p0_req_ready,
   input  logic                       p0_req_cmd,
   input  logic [ADDR_W-1:0]          p0_req_addr,
   input  logic [DATA_W-1:0]          p0_req_wdata,
   output logic                       p0_rsp_valid,
   output logic [DATA_W-1:0]          p0_rsp_data,
   input  logic                       p1_req_valid,
   output logic                       p1_req_ready,
   input  logic                       p1_req_cmd,
   input  logic [ADDR_W-1:0]          p1_req_addr,
   input  logic [DATA_W-1:0]          p1_req_wdata,
   output logic                       p1_rsp_valid,
   output logic [DATA_W-1:0]          p1_rsp_data,
   output logic                       app_en,
   output logic [2:0]                 app_cmd,
   output logic [ADDR_W-1:0]          app_addr,
   output logic                       app_wdf_wren,
   output logic                       app_wdf_end,
   output logic [DATA_W-1:0]          app_wdf_data,
   output logic [DATA_W/8-1:0]        app_wdf_mask,
   input  logic                       app_rdy,
   input  logic                       app_wdf_rdy,
   input  logic                       app_rd_data_valid,
   input  logic [DATA_W-1:0]          app_rd_data,
   output logic [$clog2(RD_DEPTH):0]  rd_outstanding,
   output logic                       rd_err
);

   localparam int PW = $clog2(RD_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] RD_FULL = CW'(RD_DEPTH);

   typedef enum logic [1:0] {S_CALIB, S_ARB, S_ISSUE} state_t;

   state_t              state_d, state_q;
   logic                rr_ptr_d, rr_ptr_q;
   logic                gnt_port_d, gnt_port_q;
   logic                app_en_d, app_en_q;
   logic [2:0]          app_cmd_d, app_cmd_q;
   logic [ADDR_W-1:0]   app_addr_d, app_addr_q;
   logic [DATA_W-1:0]   app_wdf_data_d, app_wdf_data_q;
   logic [RD_DEPTH-1:0] tag_mem_d, tag_mem_q;
   logic [PW-1:0]       wr_ptr_d, wr_ptr_q;
   logic [PW-1:0]       rd_ptr_d, rd_ptr_q;
   logic [CW-1:0]       rd_cnt_d, rd_cnt_q;
   logic                rd_err_d, rd_err_q;
   logic                p0_rsp_valid_d, p0_rsp_valid_q;
   logic                p1_rsp_valid_d, p1_rsp_valid_q;
   logic [DATA_W-1:0]   p0_rsp_data_d, p0_rsp_data_q;
   logic [DATA_W-1:0]   p1_rsp_data_d, p1_rsp_data_q;

   logic elig0, elig1, gnt_vld, gnt_sel, accept, push, pop, pop_tag;

   always_comb begin
      elig0   = p0_req_valid && (!p0_req_cmd || (rd_cnt_q < RD_FULL));
      elig1   = p1_req_valid && (!p1_req_cmd || (rd_cnt_q < RD_FULL));
      gnt_vld = (state_q == S_ARB) && init_calib_complete && (elig0 || elig1);
      gnt_sel = (elig0 && elig1) ? rr_ptr_q : elig1;
      // A read only needs the command slot; a write also needs the data FIFO.
      accept  = (state_q == S_ISSUE) && app_rdy && (app_cmd_q[0] || app_wdf_rdy);
      push    = accept && app_cmd_q[0];
      pop     = app_rd_data_valid && (rd_cnt_q != '0);
      pop_tag = tag_mem_q[rd_ptr_q];

      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      gnt_port_d     = gnt_port_q;
      app_en_d       = app_en_q;
      app_cmd_d      = app_cmd_q;
      app_addr_d     = app_addr_q;
      app_wdf_data_d = app_wdf_data_q;
      tag_mem_d      = tag_mem_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      rd_cnt_d       = rd_cnt_q;
      rd_err_d       = rd_err_q;
      p0_rsp_valid_d = 1'b0;
      p1_rsp_valid_d = 1'b0;
      p0_rsp_data_d  = p0_rsp_data_q;
      p1_rsp_data_d  = p1_rsp_data_q;

      case (state_q)
         S_CALIB: begin
            if (init_calib_complete) state_d = S_ARB;
         end
         S_ARB: begin
            if (!init_calib_complete) begin
               state_d = S_CALIB;
            end else if (gnt_vld) begin
               gnt_port_d     = gnt_sel;
               app_en_d       = 1'b1;
               app_cmd_d      = {2'b00, gnt_sel ? p1_req_cmd : p0_req_cmd};
               app_addr_d     = gnt_sel ? p1_req_addr : p0_req_addr;
               app_wdf_data_d = gnt_sel ? p1_req_wdata : p0_req_wdata;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (accept) begin
               app_en_d = 1'b0;
               rr_ptr_d = ~gnt_port_q;
               state_d  = S_ARB;
            end
         end
         default: state_d = S_CALIB;
      endcase

      if (push) begin
         tag_mem_d[wr_ptr_q] = gnt_port_q;
         wr_ptr_d            = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         if (pop_tag) begin
            p1_rsp_valid_d = 1'b1;
            p1_rsp_data_d  = app_rd_data;
         end else begin
            p0_rsp_valid_d = 1'b1;
            p0_rsp_data_d  = app_rd_data;
         end
      end
      if (app_rd_data_valid && (rd_cnt_q == '0)) rd_err_d = 1'b1;

      case ({push, pop})
         2'b10:   rd_cnt_d = rd_cnt_q + CW'(1);
         2'b01:   rd_cnt_d = rd_cnt_q - CW'(1);
         default: rd_cnt_d = rd_cnt_q;
      endcase
   end

   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         state_q        <= S_CALIB;
         rr_ptr_q       <= 1'b0;
         gnt_port_q     <= 1'b0;
         app_en_q       <= 1'b0;
         app_cmd_q      <= '0;
         app_addr_q     <= '0;
         app_wdf_data_q <= '0;
         tag_mem_q      <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         rd_cnt_q       <= '0;
         rd_err_q       <= 1'b0;
         p0_rsp_valid_q <= 1'b0;
         p1_rsp_valid_q <= 1'b0;
         p0_rsp_data_q  <= '0;
         p1_rsp_data_q  <= '0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         gnt_port_q     <= gnt_port_d;
         app_en_q       <= app_en_d;
         app_cmd_q      <= app_cmd_d;
         app_addr_q     <= app_addr_d;
         app_wdf_data_q <= app_wdf_data_d;
         tag_mem_q      <= tag_mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         rd_cnt_q       <= rd_cnt_d;
         rd_err_q       <= rd_err_d;
         p0_rsp_valid_q <= p0_rsp_valid_d;
         p1_rsp_valid_q <= p1_rsp_valid_d;
         p0_rsp_data_q  <= p0_rsp_data_d;
         p1_rsp_data_q  <= p1_rsp_data_d;
      end
   end

   assign p0_req_ready   = gnt_vld && !gnt_sel;
   assign p1_req_ready   = gnt_vld && gnt_sel;
   assign app_en         = app_en_q;
   assign app_cmd        = app_cmd_q;
   assign app_addr       = app_addr_q;
   assign app_wdf_data   = app_wdf_data_q;
   assign app_wdf_wren   = app_en_q && !app_cmd_q[0];
   assign app_wdf_end    = app_en_q && !app_cmd_q[0];
   assign app_wdf_mask   = '0;
   assign p0_rsp_valid   = p0_rsp_valid_q;
   assign p1_rsp_valid   = p1_rsp_valid_q;
   assign p0_rsp_data    = p0_rsp_data_q;
   assign p1_rsp_data    = p1_rsp_data_q;
   assign rd_outstanding = rd_cnt_q;
   assign rd_err         = rd_err_q;

endmodule
